// File: rtl/rtype_exec_unit_if.sv
// rtype_exec_unit_if: issue/result handshake bundle between the core and the R-type execute unit
interface rtype_exec_unit_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         funct;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  result;
    logic               wr_en;
    logic               special_jump;
    logic               illegal;
    logic [DATA_W-1:0]  hi;
    logic [DATA_W-1:0]  lo;
    modport master (
        output in_valid, funct, shamt, a, b, out_ready,
        input  in_ready, out_valid, result, wr_en, special_jump, illegal, hi, lo
    );
    modport slave (
        input  in_valid, funct, shamt, a, b, out_ready,
        output in_ready, out_valid, result, wr_en, special_jump, illegal, hi, lo
    );
endinterface

// File: rtl/rtype_exec_unit.sv
// rtype_exec_unit: multicycle R-type execute with HI/LO and iterative shift-add multiplier
module rtype_exec_unit #(
    parameter int DATA_W   = 32,
    parameter int SHAMT_W  = 5,
    parameter int MUL_STEP = 1
) (
    input logic               clk,
    input logic               rst,
    rtype_exec_unit_if.slave  bus
);
    localparam int N  = DATA_W / MUL_STEP;
    localparam int CW = $clog2(N) + 1;
    typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [5:0]          f;
    logic [SHAMT_W-1:0]  sh_r, s;
    logic [DATA_W-1:0]   a_r, b_r, hi_r, lo_r, mplier, mag_a, mag_b, res;
    logic [2*DATA_W-1:0] prod, mcand, step;
    logic [CW-1:0]       cnt;
    logic                neg, accept, sgn, mul_in, last, done, we, jmp, ill;
    assign accept = bus.in_valid && state == IDLE;
    assign mul_in = bus.funct[5:1] == 5'b01100;
    assign sgn    = bus.funct == 6'b011000;
    assign mag_a  = (sgn && bus.a[DATA_W-1]) ? -bus.a : bus.a;
    assign mag_b  = (sgn && bus.b[DATA_W-1]) ? -bus.b : bus.b;
    assign last   = cnt == CW'(N - 1);
    assign done   = state == DONE;
    assign s      = f[2] ? a_r[SHAMT_W-1:0] : sh_r;
    always_comb begin
        state_nx = (state == IDLE) ? (accept ? (mul_in ? MUL : DONE) : IDLE) :
                   (state == MUL)  ? (last ? FIX : MUL) :
                   (state == FIX)  ? DONE :
                   (bus.out_ready ? IDLE : DONE);
    end
    always_comb begin
        step = prod;
        for (int i = 0; i < MUL_STEP; i++) step = mplier[i] ? step + (mcand << i) : step;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            f      <= '0;
            sh_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                f      <= bus.funct;
                sh_r   <= bus.shamt;
                a_r    <= bus.a;
                b_r    <= bus.b;
                mcand  <= {{DATA_W{1'b0}}, mag_a};
                mplier <= mag_b;
                prod   <= '0;
                cnt    <= '0;
                neg    <= sgn && (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
                if (bus.funct == 6'b010001) hi_r <= bus.a;
                if (bus.funct == 6'b010011) lo_r <= bus.a;
            end
            if (state == MUL) begin
                prod   <= step;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt + 1'b1;
            end
            if (state == FIX) {hi_r, lo_r} <= neg ? -prod : prod;
        end
    end
    always_comb begin
        res = '0;
        we  = 1'b0;
        jmp = 1'b0;
        ill = 1'b0;
        case (f)
            6'b100001: begin res = a_r + b_r; we = 1'b1; end
            6'b100011: begin res = a_r - b_r; we = 1'b1; end
            6'b100100: begin res = a_r & b_r; we = 1'b1; end
            6'b100101: begin res = a_r | b_r; we = 1'b1; end
            6'b100110: begin res = a_r ^ b_r; we = 1'b1; end
            6'b100111: begin res = ~(a_r | b_r); we = 1'b1; end
            6'b101010: begin res = {{(DATA_W-1){1'b0}}, $signed(a_r) < $signed(b_r)}; we = 1'b1; end
            6'b101011: begin res = {{(DATA_W-1){1'b0}}, a_r < b_r}; we = 1'b1; end
            6'b000000, 6'b000100: begin res = b_r << s; we = 1'b1; end
            6'b000010, 6'b000110: begin res = b_r >> s; we = 1'b1; end
            6'b000011, 6'b000111: begin res = $signed(b_r) >>> s; we = 1'b1; end
            6'b001011: begin res = a_r; we = |b_r; end
            6'b001010: begin res = a_r; we = ~|b_r; end
            6'b001000, 6'b001001: begin res = a_r; jmp = 1'b1; end
            6'b010000: begin res = hi_r; we = 1'b1; end
            6'b010010: begin res = lo_r; we = 1'b1; end
            6'b010001, 6'b010011, 6'b011000, 6'b011001: ;
            default: ill = 1'b1;
        endcase
    end
    assign bus.in_ready     = state == IDLE;
    assign bus.out_valid    = done;
    assign bus.result       = done ? res : '0;
    assign bus.wr_en        = done && we;
    assign bus.special_jump = done && jmp;
    assign bus.illegal      = done && ill;
    assign bus.hi           = hi_r;
    assign bus.lo           = lo_r;
endmodule

// File: tb/tb_rtype_exec_unit.sv
// tb_rtype_exec_unit: directed table, stall/reset sequences and random ops against a reference model
module tb_rtype_exec_unit;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    rtype_exec_unit_if #(.DATA_W(W), .SHAMT_W(5)) bus ();
    rtype_exec_unit #(.DATA_W(W), .SHAMT_W(5), .MUL_STEP(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    typedef struct {
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] a, b, res;
        logic        we, jmp, ill;
        int          lat;
        logic [31:0] hi, lo;
    } vec_t;
    vec_t vecs[16];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic run_op(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic we, output logic jmp, output logic ill);
        int w = 0;
        while (!bus.in_ready && w < 100) begin @(posedge clk); #1; w++; end
        bus.in_valid = 1'b1; bus.funct = f; bus.shamt = sh; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.shamt = 5'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res = bus.result; we = bus.wr_en; jmp = bus.special_jump; ill = bus.illegal;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask
    task automatic model(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic we, output logic jmp, output logic ill, output int lat);
        longint p;
        res = '0; we = 1'b0; jmp = 1'b0; ill = 1'b0; lat = 1;
        case (f)
            6'h21: begin res = a + b; we = 1'b1; end
            6'h23: begin res = a - b; we = 1'b1; end
            6'h24: begin res = a & b; we = 1'b1; end
            6'h25: begin res = a | b; we = 1'b1; end
            6'h26: begin res = a ^ b; we = 1'b1; end
            6'h27: begin res = ~(a | b); we = 1'b1; end
            6'h2A: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; we = 1'b1; end
            6'h2B: begin res = (a < b) ? 32'd1 : 32'd0; we = 1'b1; end
            6'h00: begin res = 32'(64'(b) * (64'd1 << sh)); we = 1'b1; end
            6'h02: begin res = b / (32'd1 << sh); we = 1'b1; end
            6'h03: begin res = 32'($signed(b) >>> sh); we = 1'b1; end
            6'h04: begin res = 32'(64'(b) * (64'd1 << (a % 32))); we = 1'b1; end
            6'h06: begin res = b / (32'd1 << (a % 32)); we = 1'b1; end
            6'h07: begin res = 32'($signed(b) >>> (a % 32)); we = 1'b1; end
            6'h0B: begin res = a; we = b != 0; end
            6'h0A: begin res = a; we = b == 0; end
            6'h08, 6'h09: begin res = a; jmp = 1'b1; end
            6'h10: begin res = m_hi; we = 1'b1; end
            6'h12: begin res = m_lo; we = 1'b1; end
            6'h11: m_hi = a;
            6'h13: m_lo = a;
            6'h18: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; lat = 34; end
            6'h19: begin p = longint'({32'd0, a} * {32'd0, b}); {m_hi, m_lo} = p; lat = 34; end
            default: ill = 1'b1;
        endcase
    endtask
    initial begin
        int lat, elat;
        logic [31:0] res, eres;
        logic we, jmp, ill, ewe, ejmp, eill;
        logic [5:0] legal[24];
        legal = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04,
                  6'h06, 6'h07, 6'h0B, 6'h0A, 6'h08, 6'h09, 6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19};
        vecs[0]  = '{6'h21, 5'd0, 32'hFFFFFFFF, 32'h2,        32'h1,        1, 0, 0, 1,  32'h0,        32'h0};
        vecs[1]  = '{6'h03, 5'd4, 32'h0,        32'h80000000, 32'hF8000000, 1, 0, 0, 1,  32'h0,        32'h0};
        vecs[2]  = '{6'h07, 5'd0, 32'h24,       32'h80000000, 32'hF8000000, 1, 0, 0, 1,  32'h0,        32'h0};
        vecs[3]  = '{6'h04, 5'd7, 32'h20,       32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0, 1,  32'h0,        32'h0};
        vecs[4]  = '{6'h0B, 5'd0, 32'h1234,     32'h0,        32'h1234,     0, 0, 0, 1,  32'h0,        32'h0};
        vecs[5]  = '{6'h0A, 5'd0, 32'h1234,     32'h0,        32'h1234,     1, 0, 0, 1,  32'h0,        32'h0};
        vecs[6]  = '{6'h08, 5'd0, 32'h00400020, 32'h5,        32'h00400020, 0, 1, 0, 1,  32'h0,        32'h0};
        vecs[7]  = '{6'h3F, 5'd0, 32'h5,        32'h7,        32'h0,        0, 0, 1, 1,  32'h0,        32'h0};
        vecs[8]  = '{6'h18, 5'd0, 32'hFFFFFFFE, 32'h3,        32'h0,        0, 0, 0, 34, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[9]  = '{6'h12, 5'd0, 32'h0,        32'h0,        32'hFFFFFFFA, 1, 0, 0, 1,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[10] = '{6'h19, 5'd0, 32'hFFFFFFFE, 32'h3,        32'h0,        0, 0, 0, 34, 32'h2,        32'hFFFFFFFA};
        vecs[11] = '{6'h11, 5'd0, 32'hA5A5A5A5, 32'h0,        32'h0,        0, 0, 0, 1,  32'hA5A5A5A5, 32'hFFFFFFFA};
        vecs[12] = '{6'h10, 5'd0, 32'h0,        32'h0,        32'hA5A5A5A5, 1, 0, 0, 1,  32'hA5A5A5A5, 32'hFFFFFFFA};
        vecs[13] = '{6'h18, 5'd0, 32'h80000000, 32'h80000000, 32'h0,        0, 0, 0, 34, 32'h40000000, 32'h0};
        vecs[14] = '{6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h1,        1, 0, 0, 1,  32'h40000000, 32'h0};
        vecs[15] = '{6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 0, 1,  32'h40000000, 32'h0};
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.funct = '0; bus.shamt = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", bus.in_ready, 1);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.result", bus.result, 0);
        chk("rst.flags", {bus.wr_en, bus.special_jump, bus.illegal}, 0);
        chk("rst.hilo", {bus.hi, bus.lo}, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].funct, vecs[i].shamt, vecs[i].a, vecs[i].b, lat, res, we, jmp, ill);
            chk($sformatf("vec%0d.lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d.result", i), res, vecs[i].res);
            chk($sformatf("vec%0d.flags", i), {we, jmp, ill}, {vecs[i].we, vecs[i].jmp, vecs[i].ill});
            chk($sformatf("vec%0d.hi", i), bus.hi, vecs[i].hi);
            chk($sformatf("vec%0d.lo", i), bus.lo, vecs[i].lo);
        end
        m_hi = 32'h40000000; m_lo = 32'h0;
        // Stall in DONE with a competing in_valid that must be ignored
        bus.in_valid = 1'b1; bus.funct = 6'h21; bus.a = 32'd10; bus.b = 32'd20;
        @(posedge clk); #1;
        bus.funct = 6'h23; bus.a = 32'd99; bus.b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d.valid", i), bus.out_valid, 1);
            chk($sformatf("stall%0d.result", i), bus.result, 32'd30);
            chk($sformatf("stall%0d.wr_en", i), bus.wr_en, 1);
            chk($sformatf("stall%0d.in_ready", i), bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("release.out_valid", bus.out_valid, 0);
        chk("release.in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        chk("release.hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        // Reset in the 10th MUL cycle discards the multiply
        bus.in_valid = 1'b1; bus.funct = 6'h18; bus.a = 32'd7; bus.b = 32'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("mulrst.busy", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mulrst.in_ready", bus.in_ready, 1);
        chk("mulrst.out_valid", bus.out_valid, 0);
        chk("mulrst.hilo", {bus.hi, bus.lo}, 0);
        m_hi = '0; m_lo = '0;
        repeat (40) @(posedge clk);
        #1;
        chk("mulrst.quiet", {bus.out_valid, bus.hi, bus.lo}, 0);
        run_op(6'h21, 5'd0, 32'd5, 32'd6, lat, res, we, jmp, ill);
        chk("postrst.lat", lat, 1);
        chk("postrst.result", res, 32'd11);
        for (int i = 0; i < 80; i++) begin
            logic [5:0] f;
            logic [4:0] sh;
            logic [31:0] a, b;
            f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 23)];
            sh = 5'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            model(f, sh, a, b, eres, ewe, ejmp, eill, elat);
            run_op(f, sh, a, b, lat, res, we, jmp, ill);
            chk($sformatf("rnd%0d f=%0h lat", i, f), lat, elat);
            chk($sformatf("rnd%0d f=%0h result", i, f), res, eres);
            chk($sformatf("rnd%0d f=%0h flags", i, f), {we, jmp, ill}, {ewe, ejmp, eill});
            chk($sformatf("rnd%0d f=%0h hilo", i, f), {bus.hi, bus.lo}, {m_hi, m_lo});
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
